mem_bus_controller: RTL and testbench

- Sequences every access to the single-port main memory and shares that port between two requesters: the CPU control path and a debug/program loader.
- On the CPU side it consumes MREQ_N and R_W_N from the instruction decoder, and returns the one-cycle ACK that the status counter waits on before advancing IF/FF/TF/EX states.
- The memory side uses a ready handshake, so memory latency is variable.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 44 ++++
 rtl/mem_bus_controller.sv | 179 +++++++++++++++++
 tb/tb_mem_bus_controller.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the main-memory bus controller.
// State encoding, owner ids, timeout abort pattern and default timeout.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LD  = 1'b1;

    // Read data returned on a timeout abort; sliced to DW (DW <= 64)
    localparam logic [63:0] ERR_RDATA = {64{1'b1}};

    localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant (CPU vs loader).
// The last winner loses the next tie; reset favours the CPU.
module rr_arbiter2
    import mem_bus_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic req_cpu_i,
    input  logic req_ld_i,
    output logic gnt_o,
    output logic owner_o
);

    logic last_q;
    logic last_d;
    logic owner;

    // Pick the winner and remember it whenever a grant is issued
    always_comb begin
        owner  = OWN_CPU;
        last_d = last_q;
        if (req_cpu_i && req_ld_i) begin
            owner = ~last_q;
        end else if (req_ld_i) begin
            owner = OWN_LD;
        end
        gnt_o   = en_i && (req_cpu_i || req_ld_i);
        owner_o = owner;
        if (gnt_o) begin
            last_d = owner;
        end
    end

    // Round-robin history register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= OWN_LD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_bus_controller.sv
// mem_bus_controller: sequences main-memory accesses for CPU and loader.
// Optional timeout abort is built when MEMBUS_TIMEOUT_EN is defined.
module mem_bus_controller
    import mem_bus_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          MREQ_N,
    input  logic          R_W_N,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          ACK,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy,
    output logic          busy,
    output logic          bus_err
);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] crd_q, crd_d;
    logic [DW-1:0] lrd_q, lrd_d;
    logic          err_q, err_d;
    logic          gnt;
    logic          gnt_owner;
    logic          in_idle;

    assign in_idle = (state_q == IDLE);

    rr_arbiter2 u_arb (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .en_i      (in_idle),
        .req_cpu_i (~MREQ_N),
        .req_ld_i  (ld_req),
        .gnt_o     (gnt),
        .owner_o   (gnt_owner)
    );

`ifdef MEMBUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo;

    assign tmo = (cnt_q == CW'(TIMEOUT - 1));

    // Count ACCESS cycles; cleared when a new access is granted
    always_comb begin
        cnt_d = cnt_q;
        if (in_idle && gnt) begin
            cnt_d = '0;
        end else if (state_q == ACCESS) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic tmo;
    logic unused_timeout;

    assign tmo            = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Next state, request latching and read-data capture
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        crd_d   = crd_q;
        lrd_d   = lrd_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (gnt) begin
                    state_d = ACCESS;
                    owner_d = gnt_owner;
                    if (gnt_owner == OWN_CPU) begin
                        we_d    = ~R_W_N;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        we_d    = ld_we;
                        addr_d  = ld_addr;
                        wdata_d = ld_wdata;
                    end
                end
            end
            ACCESS: begin
                if (mem_rdy) begin
                    state_d = DONE;
                    if (owner_q == OWN_CPU) begin
                        crd_d = mem_rdata;
                    end else begin
                        lrd_d = mem_rdata;
                    end
                end else if (tmo) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (owner_q == OWN_CPU) begin
                        crd_d = ERR_RDATA[DW-1:0];
                    end else begin
                        lrd_d = ERR_RDATA[DW-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            crd_q   <= '0;
            lrd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            crd_q   <= crd_d;
            lrd_q   <= lrd_d;
            err_q   <= err_d;
        end
    end

    assign mem_cs    = (state_q == ACCESS);
    assign mem_we    = mem_cs && we_q;
    assign mem_addr  = mem_cs ? addr_q : '0;
    assign mem_wdata = mem_cs ? wdata_q : '0;
    assign ACK       = (state_q == DONE) && (owner_q == OWN_CPU);
    assign ld_ack    = (state_q == DONE) && (owner_q == OWN_LD);
    assign bus_err   = (state_q == DONE) && err_q;
    assign busy      = !in_idle;
    assign cpu_rdata = crd_q;
    assign ld_rdata  = lrd_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// tb_mem_bus_controller: directed vector table plus multi-cycle sequences.
// Covers arbitration, wait states, latching, reset abort and timeout.
module tb_mem_bus_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        MREQ_N = 1'b1;
    logic        R_W_N = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        ACK;
    logic [15:0] cpu_rdata;
    logic        ld_req = 1'b0;
    logic        ld_we = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [15:0] ld_wdata = '0;
    logic        ld_ack;
    logic [15:0] ld_rdata;
    logic        mem_cs;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_rdy = 1'b0;
    logic        busy;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_controller #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .MREQ_N    (MREQ_N),
        .R_W_N     (R_W_N),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .ACK       (ACK),
        .cpu_rdata (cpu_rdata),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_ack    (ld_ack),
        .ld_rdata  (ld_rdata),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .busy      (busy),
        .bus_err   (bus_err)
    );

    typedef struct {
        logic        rs;
        logic        mq;
        logic        rw;
        logic [15:0] ca;
        logic        lr;
        logic        lw;
        logic [15:0] la;
        logic [15:0] ld;
        logic        rdy;
        logic [15:0] rd;
        logic [69:0] ex;
    } vec_t;

    function automatic logic [69:0] obs();
        return {ACK, ld_ack, mem_cs, mem_we, busy, bus_err,
                mem_addr, mem_wdata, cpu_rdata, ld_rdata};
    endfunction

    function automatic logic [69:0] e(input logic a, la, cs, we, bz,
                                      input logic [15:0] ad, wd, cr, lr);
        return {a, la, cs, we, bz, 1'b0, ad, wd, cr, lr};
    endfunction

    function automatic vec_t v(input logic rs, mq, rw,
                               input logic [15:0] ca,
                               input logic lr, lw,
                               input logic [15:0] la, ld,
                               input logic rdy,
                               input logic [15:0] rd,
                               input logic [69:0] ex);
        vec_t t;
        t.rs = rs; t.mq = mq; t.rw = rw; t.ca = ca;
        t.lr = lr; t.lw = lw; t.la = la; t.ld = ld;
        t.rdy = rdy; t.rd = rd; t.ex = ex;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [69:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    vec_t tv[20];

    initial begin
        int cs_n, acks, busy_n, bad, lat;
        bit seen;

        // rst mq rw ca  lr lw la ld rdy rd  expected
        tv[0]  = v(0,1,1,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000));
        tv[1]  = v(1,0,1,16'h0010,0,0,16'h0000,16'h0000,0,16'h0000,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000));
        tv[2]  = v(1,0,1,16'h0010,0,0,16'h0000,16'h0000,1,16'hA5A5,
                   e(0,0,1,0,1,16'h0010,16'h0000,16'h0000,16'h0000));
        tv[3]  = v(1,1,1,16'h0010,0,0,16'h0000,16'h0000,0,16'h0000,
                   e(1,0,0,0,1,16'h0000,16'h0000,16'hA5A5,16'h0000));
        tv[4]  = v(1,1,1,16'h0000,0,0,16'h0000,16'h0000,1,16'hBBBB,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'hA5A5,16'h0000));
        tv[5]  = v(1,1,1,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'hA5A5,16'h0000));
        tv[6]  = v(0,1,1,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000));
        tv[7]  = v(1,0,1,16'h0020,1,1,16'h0030,16'h1234,0,16'h0000,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'h0000,16'h0000));
        tv[8]  = v(1,0,1,16'h0020,1,1,16'h0030,16'h1234,1,16'h1111,
                   e(0,0,1,0,1,16'h0020,16'h0000,16'h0000,16'h0000));
        tv[9]  = v(1,0,1,16'h0020,1,1,16'h0030,16'h1234,0,16'h0000,
                   e(1,0,0,0,1,16'h0000,16'h0000,16'h1111,16'h0000));
        tv[10] = v(1,0,1,16'h0020,1,1,16'h0030,16'h1234,0,16'h0000,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'h1111,16'h0000));
        tv[11] = v(1,0,1,16'h0020,1,1,16'h0030,16'h1234,1,16'h2222,
                   e(0,0,1,1,1,16'h0030,16'h1234,16'h1111,16'h0000));
        tv[12] = v(1,1,1,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
                   e(0,1,0,0,1,16'h0000,16'h0000,16'h1111,16'h2222));
        tv[13] = v(1,0,1,16'h0040,1,0,16'h0050,16'h0000,0,16'h0000,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'h1111,16'h2222));
        tv[14] = v(1,0,1,16'h0040,1,0,16'h0050,16'h0000,1,16'h3333,
                   e(0,0,1,0,1,16'h0040,16'h0000,16'h1111,16'h2222));
        tv[15] = v(1,0,1,16'h0040,1,0,16'h0050,16'h0000,0,16'h0000,
                   e(1,0,0,0,1,16'h0000,16'h0000,16'h3333,16'h2222));
        tv[16] = v(1,0,1,16'h0040,1,0,16'h0050,16'h0000,0,16'h0000,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'h3333,16'h2222));
        tv[17] = v(1,1,1,16'h0000,0,0,16'h0000,16'h0000,1,16'h4444,
                   e(0,0,1,0,1,16'h0050,16'h0000,16'h3333,16'h2222));
        tv[18] = v(1,1,1,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
                   e(0,1,0,0,1,16'h0000,16'h0000,16'h3333,16'h4444));
        tv[19] = v(1,1,1,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000,
                   e(0,0,0,0,0,16'h0000,16'h0000,16'h3333,16'h4444));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            reset_n   = tv[i].rs;
            MREQ_N    = tv[i].mq;
            R_W_N     = tv[i].rw;
            cpu_addr  = tv[i].ca;
            ld_req    = tv[i].lr;
            ld_we     = tv[i].lw;
            ld_addr   = tv[i].la;
            ld_wdata  = tv[i].ld;
            mem_rdy   = tv[i].rdy;
            mem_rdata = tv[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs(), tv[i].ex);
            @(posedge clk);
            #1;
        end

        // Loader read with four wait states
        @(negedge clk);
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0060;
        mem_rdata = 16'h6060; mem_rdy = 1'b0;
        cs_n = 0; acks = 0; busy_n = 0; bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy) begin busy_n++; ld_req = 1'b0; end
            if (mem_cs) begin
                cs_n++;
                if (mem_addr !== 16'h0060) bad++;
            end
            if (ld_ack) acks++;
            mem_rdy = mem_cs && (cs_n == 5);
        end
        chk("wait_cs_cycles", 70'(cs_n), 70'(5));
        chk("wait_ld_ack", 70'(acks), 70'(1));
        chk("wait_addr_stable", 70'(bad), 70'(0));
        chk("wait_busy_cycles", 70'(busy_n), 70'(6));
        chk("wait_ld_rdata", 70'(ld_rdata), 70'(16'h6060));

        // CPU write whose inputs change after the grant
        MREQ_N = 1'b0; R_W_N = 1'b0; cpu_addr = 16'h0070;
        cpu_wdata = 16'hBEEF; mem_rdata = 16'hC0DE; mem_rdy = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_cs;
        end
        chk("chg_granted", 70'(seen), 70'(1));
        cpu_addr = 16'hFFFF; cpu_wdata = 16'h0000; MREQ_N = 1'b1;
        bad = 0; acks = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (!mem_cs || !mem_we || mem_addr !== 16'h0070 ||
                mem_wdata !== 16'hBEEF) bad++;
        end
        mem_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_rdy = 1'b0;
            if (ACK) acks++;
        end
        chk("chg_latched", 70'(bad), 70'(0));
        chk("chg_ack", 70'(acks), 70'(1));

        // Reset while an access is in flight
        MREQ_N = 1'b0; R_W_N = 1'b1; cpu_addr = 16'h0080;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = mem_cs;
        end
        chk("rst_granted", 70'(seen), 70'(1));
        #2 reset_n = 1'b0;
        MREQ_N = 1'b1;
        #1 chk("rst_outputs", obs(), 70'(0));
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (ACK || ld_ack) acks++;
        end
        reset_n = 1'b1;
        @(negedge clk);
        if (ACK || ld_ack) acks++;
        chk("rst_no_ack", 70'(acks), 70'(0));
        MREQ_N = 1'b0; cpu_addr = 16'h0090;
        mem_rdata = 16'h5A5A; mem_rdy = 1'b1;
        lat = -1;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            if (busy) MREQ_N = 1'b1;
            if (ACK) lat = c;
        end
        mem_rdy = 1'b0;
        chk("rst_recover_lat", 70'(lat), 70'(2));
        chk("rst_recover_data", 70'(cpu_rdata), 70'(16'h5A5A));

        // Memory never ready
        @(negedge clk);
        MREQ_N = 1'b0; R_W_N = 1'b1; cpu_addr = 16'h00A0; mem_rdy = 1'b0;
`ifdef MEMBUS_TIMEOUT_EN
        cs_n = 0; acks = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) MREQ_N = 1'b1;
            if (mem_cs) cs_n++;
            if (ACK) begin
                acks++;
                if (!bus_err || cpu_rdata !== 16'hFFFF) bad++;
            end
        end
        chk("tmo_cs_cycles", 70'(cs_n), 70'(8));
        chk("tmo_ack", 70'(acks), 70'(1));
        chk("tmo_err_data", 70'(bad), 70'(0));
`else
        acks = 0; bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) MREQ_N = 1'b1;
            if (ACK) acks++;
            if (bus_err) bad++;
        end
        chk("notmo_no_ack", 70'(acks), 70'(0));
        chk("notmo_still_cs", 70'({mem_cs, busy}), 70'(2'b11));
        mem_rdata = 16'h7777; mem_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_rdy = 1'b0;
            if (ACK) acks++;
            if (bus_err) bad++;
        end
        chk("notmo_ack", 70'(acks), 70'(1));
        chk("notmo_no_err", 70'(bad), 70'(0));
        chk("notmo_data", 70'(cpu_rdata), 70'(16'h7777));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
